// File: rtl/ide_pkg.sv
// Shared definitions for the ATA/IDE PIO register-access engine:
// FSM state type, ATA task-file addresses, status bits and command opcodes.
package ide_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } ide_state_e;

  // Addresses are {CS1-,CS0-,DA[2:0]}; register pairs share an address by direction.
  localparam logic [4:0] ATA_DATA     = 5'b10000;
  localparam logic [4:0] ATA_ERROR    = 5'b10001;
  localparam logic [4:0] ATA_FEATURE  = 5'b10001;
  localparam logic [4:0] ATA_SECCNT   = 5'b10010;
  localparam logic [4:0] ATA_SECNUM   = 5'b10011;
  localparam logic [4:0] ATA_CYLLOW   = 5'b10100;
  localparam logic [4:0] ATA_CYLHIGH  = 5'b10101;
  localparam logic [4:0] ATA_DRVHEAD  = 5'b10110;
  localparam logic [4:0] ATA_STATUS   = 5'b10111;
  localparam logic [4:0] ATA_COMMAND  = 5'b10111;
  localparam logic [4:0] ATA_ALTER    = 5'b01110;
  localparam logic [4:0] ATA_DEVCTRL  = 5'b01110;

  localparam int STAT_BSY  = 7;
  localparam int STAT_DRDY = 6;
  localparam int STAT_DWF  = 5;
  localparam int STAT_DSC  = 4;
  localparam int STAT_DRQ  = 3;
  localparam int STAT_CORR = 2;
  localparam int STAT_IDX  = 1;
  localparam int STAT_ERR  = 0;

  localparam logic [7:0] ATA_CMD_READ  = 8'h20;
  localparam logic [7:0] ATA_CMD_WRITE = 8'h30;

  // A zero-length phase is meaningless on the bus, so it is stretched to one cycle.
  function automatic int legalCycles(input int t);
    return (t < 1) ? 1 : t;
  endfunction

endpackage

// File: rtl/ide_pio_if.sv
// Request/response handshake and IDE control pins of the PIO engine.
// The bidirectional data bus stays a plain port on the engine itself.
interface ide_pio_if;

  logic        ata_rd;
  logic        ata_wr;
  logic [4:0]  ata_addr;
  logic [15:0] ata_in;
  logic [15:0] ata_out;
  logic        ata_done;
  logic        ide_dior;
  logic        ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;

  modport master (
    output ata_rd, ata_wr, ata_addr, ata_in,
    input  ata_out, ata_done, ide_dior, ide_diow, ide_cs, ide_da
  );

  modport slave (
    input  ata_rd, ata_wr, ata_addr, ata_in,
    output ata_out, ata_done, ide_dior, ide_diow, ide_cs, ide_da
  );

endinterface

// File: rtl/ide_pio.sv
// ATA/IDE PIO engine: runs one register read or write as a timed
// SETUP/PULSE/HOLD bus cycle and returns a one-cycle done strobe.
module ide_pio
  import ide_pkg::*;
#(
  parameter int T_SETUP = 4,
  parameter int T_PULSE = 9,
  parameter int T_HOLD  = 2
) (
  input  logic        clk,
  input  logic        reset,
  ide_pio_if.slave    bus,
  inout  wire  [15:0] ide_data_bus
);

  localparam int SETUP_C = legalCycles(T_SETUP);
  localparam int PULSE_C = legalCycles(T_PULSE);
  localparam int HOLD_C  = legalCycles(T_HOLD);
  localparam int MAX_C   = (SETUP_C > PULSE_C) ? ((SETUP_C > HOLD_C) ? SETUP_C : HOLD_C)
                                               : ((PULSE_C > HOLD_C) ? PULSE_C : HOLD_C);
  localparam int CNT_W   = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_C - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_C - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_C - 1);

  ide_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             isRead_q;
  logic [15:0]      wdata_q;
  logic             oe_q;
  logic [15:0]      out_q;
  logic             done_q;
  logic             dior_q;
  logic             diow_q;
  logic [1:0]       cs_q;
  logic [2:0]       da_q;

  // Every pin is a flop: the next-state decisions also set next-cycle pin values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      isRead_q <= 1'b0;
      wdata_q  <= '0;
      oe_q     <= 1'b0;
      out_q    <= '0;
      done_q   <= 1'b0;
      dior_q   <= 1'b1;
      diow_q   <= 1'b1;
      cs_q     <= 2'b11;
      da_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ata_rd || bus.ata_wr) begin
            isRead_q <= bus.ata_rd;
            wdata_q  <= bus.ata_in;
            oe_q     <= !bus.ata_rd;
            cs_q     <= bus.ata_addr[4:3];
            da_q     <= bus.ata_addr[2:0];
            cnt_q    <= SETUP_LD;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            dior_q  <= !isRead_q;
            diow_q  <= isRead_q;
            cnt_q   <= PULSE_LD;
            state_q <= PULSE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            dior_q <= 1'b1;
            diow_q <= 1'b1;
            if (isRead_q) begin
              out_q <= ide_data_bus;
            end
            cnt_q   <= HOLD_LD;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            oe_q    <= 1'b0;
            cs_q    <= 2'b11;
            da_q    <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ide_data_bus = oe_q ? wdata_q : 16'hzzzz;

  assign bus.ata_out  = out_q;
  assign bus.ata_done = done_q;
  assign bus.ide_dior = dior_q;
  assign bus.ide_diow = diow_q;
  assign bus.ide_cs   = cs_q;
  assign bus.ide_da   = da_q;

endmodule

// File: tb/tb_ide_pio.sv
// Self-checking bench for ide_pio: a cycle-offset transaction model checked
// every cycle, plus directed and randomized register accesses.
module tb_ide_pio;
  import ide_pkg::*;

  localparam int T_SETUP     = 4;
  localparam int T_PULSE     = 9;
  localparam int T_HOLD      = 2;
  localparam int PULSE_FIRST = T_SETUP + 1;
  localparam int PULSE_LAST  = T_SETUP + T_PULSE;
  localparam int DONE_PH     = T_SETUP + T_PULSE + T_HOLD + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] devData = 16'h0000;
  wire  [15:0] ide_data_bus;
  int          checks = 0;
  int          errors = 0;

  ide_pio_if pins();

  ide_pio #(
    .T_SETUP(T_SETUP),
    .T_PULSE(T_PULSE),
    .T_HOLD (T_HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (pins),
    .ide_data_bus(ide_data_bus)
  );

  // The simulated drive answers reads whenever DIOR- is low.
  assign ide_data_bus = (pins.ide_dior == 1'b0) ? devData : 16'hzzzz;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkReleased(input string name);
    checks++;
    if (!($isunknown(ide_data_bus) || ide_data_bus == 16'h0000)) begin
      errors++;
      $display("[TB] FAIL %s: bus driven with 0x%0h, expected released at %0t", name, ide_data_bus, $time);
    end
  endtask

  // Model: mPhase counts cycles since acceptance (0 = idle, DONE_PH = done cycle).
  int          mPhase = 0;
  logic        mRead = 1'b0;
  logic [4:0]  mAddr = '0;
  logic [15:0] mData = '0;
  logic [15:0] mOut = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mPhase <= 0;
      mOut   <= '0;
    end else if (mPhase == 0) begin
      if (pins.ata_rd || pins.ata_wr) begin
        mPhase <= 1;
        mRead  <= pins.ata_rd;
        mAddr  <= pins.ata_addr;
        mData  <= pins.ata_in;
      end
    end else begin
      if (mPhase == PULSE_LAST && mRead) mOut <= devData;
      mPhase <= (mPhase == DONE_PH) ? 0 : mPhase + 1;
    end
  end

  wire       mActive = (mPhase >= 1) && (mPhase < DONE_PH);
  wire       mStrobe = (mPhase >= PULSE_FIRST) && (mPhase <= PULSE_LAST);
  wire [7:0] expPins = {(mActive ? mAddr : 5'b11000), !(mStrobe && mRead),
                        !(mStrobe && !mRead), (mPhase == DONE_PH)};
  wire [7:0] actPins = {pins.ide_cs, pins.ide_da, pins.ide_dior, pins.ide_diow, pins.ata_done};

  always @(negedge clk) begin
    checkOutput("pins{cs,da,dior,diow,done}", {24'b0, actPins}, {24'b0, expPins});
    checkOutput("ata_out", {16'b0, pins.ata_out}, {16'b0, mOut});
    if (mActive && !mRead) checkOutput("bus_wdata", {16'b0, ide_data_bus}, {16'b0, mData});
    else if (mStrobe && mRead) checkOutput("bus_rdata", {16'b0, ide_data_bus}, {16'b0, devData});
    else checkReleased("bus_released");
  end

  task automatic waitDone(input int dropAt, output int cycles, output int lowCnt,
                          output logic [4:0] snapAddr);
    logic sawDone;
    cycles   = 0;
    lowCnt   = 0;
    sawDone  = 1'b0;
    snapAddr = '0;
    while (!sawDone && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (!pins.ide_dior || !pins.ide_diow) lowCnt++;
      if (cycles == 4) snapAddr = {pins.ide_cs, pins.ide_da};
      if (cycles == dropAt) begin
        pins.ata_rd = 1'b0;
        pins.ata_wr = 1'b0;
      end
      if (pins.ata_done) sawDone = 1'b1;
    end
    if (!sawDone) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [4:0] addr,
                               input logic [15:0] din, input logic [15:0] dev, input int dropAt,
                               output int cycles, output int lowCnt, output logic [4:0] snapAddr);
    @(posedge clk);
    #2;
    devData       = dev;
    pins.ata_addr = addr;
    pins.ata_in   = din;
    pins.ata_rd   = rd;
    pins.ata_wr   = wr;
    waitDone(dropAt, cycles, lowCnt, snapAddr);
    pins.ata_rd = 1'b0;
    pins.ata_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         cyc;
    int         low;
    logic [4:0] snap;
    logic       rd;
    logic       wr;
    logic [15:0] dev;

    pins.ata_rd   = 1'b0;
    pins.ata_wr   = 1'b0;
    pins.ata_addr = '0;
    pins.ata_in   = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_dior", 32'(pins.ide_dior), 32'd1);
    checkOutput("rst_diow", 32'(pins.ide_diow), 32'd1);
    checkOutput("rst_cs", 32'(pins.ide_cs), 32'd3);
    checkOutput("rst_da", 32'(pins.ide_da), 32'd0);
    checkOutput("rst_ata_out", 32'(pins.ata_out), 32'd0);
    checkOutput("rst_done", 32'(pins.ata_done), 32'd0);
    checkReleased("rst_bus");
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] write SECCNT");
    applyStimulus(1'b0, 1'b1, ATA_SECCNT, 16'h0001, 16'h0000, 0, cyc, low, snap);
    checkOutput("wr_latency", 32'(cyc - 1), 32'd16);
    checkOutput("wr_diow_low", 32'(low), 32'd9);
    checkOutput("wr_addr", 32'(snap), 32'b10010);

    $display("[TB] read STATUS");
    applyStimulus(1'b1, 1'b0, ATA_STATUS, 16'hABCD, 16'h0050, 0, cyc, low, snap);
    checkOutput("rd_out_done", 32'(pins.ata_out), 32'h0050);
    checkOutput("rd_latency", 32'(cyc - 1), 32'd16);
    checkOutput("rd_dior_low", 32'(low), 32'd9);
    checkOutput("rd_addr", 32'(snap), 32'b10111);
    repeat (5) @(negedge clk);
    checkOutput("rd_out_held", 32'(pins.ata_out), 32'h0050);
    applyStimulus(1'b0, 1'b1, ATA_DATA, 16'h1234, 16'h0000, 0, cyc, low, snap);
    checkOutput("wr_keeps_out", 32'(pins.ata_out), 32'h0050);

    $display("[TB] held polling ALTSTATUS");
    @(posedge clk);
    #2;
    devData       = 16'h0080;
    pins.ata_addr = ATA_ALTER;
    pins.ata_in   = 16'h0001;
    pins.ata_rd   = 1'b1;
    waitDone(0, cyc, low, snap);
    checkOutput("poll1_out", 32'(pins.ata_out), 32'h0080);
    checkOutput("poll1_addr", 32'(snap), 32'b01110);
    devData = 16'h0058;
    waitDone(0, cyc, low, snap);
    checkOutput("poll2_spacing", 32'(cyc), 32'd17);
    checkOutput("poll2_out", 32'(pins.ata_out), 32'h0058);
    pins.ata_rd = 1'b0;

    $display("[TB] request dropped mid-cycle");
    applyStimulus(1'b0, 1'b1, ATA_CYLLOW, 16'h5A5A, 16'h0000, 8, cyc, low, snap);
    checkOutput("drop_wr_latency", 32'(cyc - 1), 32'd16);
    applyStimulus(1'b1, 1'b0, ATA_CYLHIGH, 16'h0101, 16'h00C3, 9, cyc, low, snap);
    checkOutput("drop_rd_latency", 32'(cyc - 1), 32'd16);
    checkOutput("drop_rd_out", 32'(pins.ata_out), 32'h00C3);

    $display("[TB] async reset during write pulse");
    @(posedge clk);
    #2;
    pins.ata_addr = ATA_COMMAND;
    pins.ata_in   = {8'h00, ATA_CMD_WRITE};
    pins.ata_wr   = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("pre_rst_diow_low", 32'(pins.ide_diow), 32'd0);
    #1 reset = 1'b0;
    #1;
    checkOutput("midrst_diow", 32'(pins.ide_diow), 32'd1);
    checkOutput("midrst_cs", 32'(pins.ide_cs), 32'd3);
    checkOutput("midrst_done", 32'(pins.ata_done), 32'd0);
    checkOutput("midrst_out", 32'(pins.ata_out), 32'd0);
    checkReleased("midrst_bus");
    pins.ata_wr = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    applyStimulus(1'b0, 1'b1, ATA_DRVHEAD, 16'h00E0, 16'h0000, 0, cyc, low, snap);
    checkOutput("postrst_latency", 32'(cyc - 1), 32'd16);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 40; n++) begin
      rd  = 1'($urandom_range(0, 1));
      wr  = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      dev = 16'($urandom);
      applyStimulus(rd, wr, 5'($urandom), 16'($urandom_range(1, 65535)), dev,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 15)) : 0,
                    cyc, low, snap);
      checkOutput("rnd_latency", 32'(cyc - 1), 32'd16);
      checkOutput("rnd_strobe_low", 32'(low), 32'd9);
      if (rd) checkOutput("rnd_read_out", 32'(pins.ata_out), 32'(dev));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ide_pio.md
Name: ide_pio

Overview:
- Low-level ATA/IDE PIO register-access engine.
- Turns a single register read or write request from a higher-level disk controller (block sequencer) into correctly timed IDE bus cycles: CS, DA, DIOR-, DIOW-, 16-bit data.
- Returns read data plus a one-cycle completion strobe.
- One transaction in flight at a time; no buffering.

Parameters:
- T_SETUP, 4, clk cycles address/CS are valid before the strobe asserts (≥70 ns at 50 MHz).
- T_PULSE, 9, clk cycles DIOR-/DIOW- are held low (≥165 ns).
- T_HOLD, 2, clk cycles address/CS/write data are held after the strobe deasserts.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ata_rd  in  1  request register read; level, held until ata_done
- ata_wr  in  1  request register write; level, held until ata_done
- ata_addr  in  5  {cs[1:0], da[2:0]}; e.g. 10000 DATA, 10111 STATUS/COMMAND, 01110 ALTSTATUS/DEVCTRL
- ata_in  in  16  write data
- ata_out  out  16  last read data, registered
- ata_done  out  1  one-cycle completion strobe
- ide_data_bus  inout  16  IDE DD[15:0]
- ide_dior  out  1  DIOR-, active low
- ide_diow  out  1  DIOW-, active low
- ide_cs  out  2  CS1-/CS0-, active low
- ide_da  out  3  DA[2:0]

Behaviour:
- Reset (reset=0, async) puts the FSM in IDLE and drives:
  - ata_out=0, ata_done=0
  - ide_dior=1, ide_diow=1
  - ide_cs=2'b11, ide_da=0
  - ide_data_bus high-Z
- States: IDLE, SETUP, PULSE, HOLD, DONE. A single down-counter times each phase.
- IDLE:
  - If ata_rd or ata_wr is high, capture ata_addr, ata_in and direction into registers, then go to SETUP.
  - If both are high, read wins.
  - Signals sampled only here; later changes to request inputs do not affect an in-flight cycle.
- SETUP (T_SETUP cycles): ide_cs/ide_da = captured address. On a write, drive the bus with captured data.
- PULSE (T_PULSE cycles): ide_dior=0 (read) or ide_diow=0 (write). Address and write data stay driven.
- Read data capture: on the last PULSE cycle, ata_out <= ide_data_bus, registered at the edge where the strobe rises.
- HOLD (T_HOLD cycles): strobes high; address and write data still driven.
- DONE (1 cycle):
  - ata_done=1; ata_out already valid this cycle.
  - cs=11, bus released.
  - Next state IDLE.
- Latency: done asserts T_SETUP+T_PULSE+T_HOLD+1 cycles after acceptance. Minimum one IDLE cycle between transactions.
- A requester that keeps ata_rd high after done (status polling) gets back-to-back transactions, each with its own done pulse.
- ata_out holds its value until the next read completes; writes never modify it.
- Request dropped mid-cycle: the cycle still completes and done still pulses.
- Reset mid-cycle: immediate return to IDLE values; strobes never glitch low.
- The data bus is driven only during SETUP/PULSE/HOLD of a write; otherwise high-Z.
- All outputs are registered, with no combinational paths from inputs to IDE pins.
- Counter width: enough for max(T_*). A T_* value of 0 is illegal; treat it as 1.

Decomposition:
- Shared package ide_pkg holds:
  - state enum
  - ATA register address constants (ATA_DATA, ATA_ERROR/FEATURE, ATA_SECCNT, ATA_SECNUM, ATA_CYLLOW, ATA_CYLHIGH, ATA_DRVHEAD, ATA_STATUS/COMMAND, ATA_ALTER/DEVCTRL)
  - status bit indices (BSY=7, DRDY=6, DWF=5, DSC=4, DRQ=3, CORR=2, IDX=1, ERR=0)
  - ATA_CMD_READ=0x20, ATA_CMD_WRITE=0x30
- No sub-module; the phase counter stays inline.

Test Plan:
- Reset:
  - Stimulus: hold reset=0.
  - Required: dior=diow=1, cs=11, da=0, bus Z, ata_out=0, ata_done=0.
- Write SECCNT:
  - Stimulus: ata_wr=1, addr=10010, in=0x0001.
  - Required: cs=10, da=010; bus=0x0001 from SETUP to HOLD end; diow low exactly 9 cycles; done pulse once 16 cycles after acceptance; then bus Z.
- Read STATUS:
  - Stimulus: bus model drives 0x0050 while dior is low.
  - Required: cs=10, da=111; dior low 9 cycles; ata_out=0x0050 in the done cycle and held afterwards; bus never driven by the DUT.
- Held polling:
  - Stimulus: ata_rd held high on ALTSTATUS (01110); model returns 0x0080, then 0x0058.
  - Required: cs=01, da=110; consecutive transactions with one done per transaction; ata_out tracks 0x0080 then 0x0058.
- Request dropped:
  - Stimulus: deassert ata_wr during PULSE.
  - Required: full cycle completes and done still pulses.
- Async reset mid-write:
  - Stimulus: async reset low during PULSE.
  - Required: diow=1 and bus Z immediately; no done; next request after release runs normally.
